// File: rtl/sar_ctrl.sv
// SAR sequencer for one ADC slice: drives track/hold, cap-DAC trial code and comparator
// strobe, and collects the comparator decisions into an NBITS result.
module sar_ctrl #(
    parameter int unsigned NBITS         = 8,
    parameter int unsigned SAMPLE_CYCLES = 2,
    parameter int unsigned CMP_TIMEOUT   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_done,
    input  logic             cmp_vop,
    input  logic             cmp_von,
    output logic             cmp_clk,
    output logic             sample,
    output logic [NBITS-1:0] dac_code,
    output logic [NBITS-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             cmp_err
);

    localparam int unsigned CntMax = (SAMPLE_CYCLES > CMP_TIMEOUT) ? SAMPLE_CYCLES : CMP_TIMEOUT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned IdxW   = $clog2(NBITS);

    localparam logic [CntW-1:0] SampleLast  = CntW'(SAMPLE_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(CMP_TIMEOUT - 1);
    localparam logic [IdxW-1:0] IdxTop      = IdxW'(NBITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSample,
        StCompare,
        StRelease,
        StDone
    } state_e;

    state_e          state_q;
    logic [1:0]      done_sync_q;
    logic [IdxW-1:0] idx_q;
    logic [CntW-1:0] cnt_q;

    logic            done_s;
    logic            cnt_last;
    logic [IdxW-1:0] idx_dn;

    assign done_s   = done_sync_q[1];
    assign cnt_last = (cnt_q == TimeoutLast);
    assign idx_dn   = idx_q - 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            done_sync_q <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            cmp_clk     <= 1'b0;
            sample      <= 1'b0;
            dac_code    <= '0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            busy        <= 1'b0;
            cmp_err     <= 1'b0;
        end else begin
            // cmp_done comes from the self-timed comparator, asynchronous to clk
            done_sync_q <= {done_sync_q[0], cmp_done};
            dout_valid  <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q  <= StSample;
                        sample   <= 1'b1;
                        dac_code <= '0;
                        cmp_err  <= 1'b0;
                        busy     <= 1'b1;
                        cnt_q    <= '0;
                    end
                end

                StSample: begin
                    if (cnt_q == SampleLast) begin
                        state_q          <= StCompare;
                        sample           <= 1'b0;
                        idx_q            <= IdxTop;
                        dac_code[IdxTop] <= 1'b1;
                        cmp_clk          <= 1'b1;
                        cnt_q            <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StCompare: begin
                    if (done_s) begin
                        dac_code[idx_q] <= cmp_vop;
                        if (cmp_vop == cmp_von) begin
                            cmp_err <= 1'b1;
                        end
                        cmp_clk <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StRelease;
                    end else if (cnt_last) begin
                        // No decision in time: keep the trial bit and flag it
                        dac_code[idx_q] <= 1'b1;
                        cmp_err         <= 1'b1;
                        cmp_clk         <= 1'b0;
                        cnt_q           <= '0;
                        state_q         <= StRelease;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StRelease: begin
                    if (!done_s || cnt_last) begin
                        if (done_s) begin
                            cmp_err <= 1'b1;
                        end
                        cnt_q <= '0;
                        if (idx_q != '0) begin
                            idx_q            <= idx_dn;
                            dac_code[idx_dn] <= 1'b1;
                            cmp_clk          <= 1'b1;
                            state_q          <= StCompare;
                        end else begin
                            dout       <= dac_code;
                            dout_valid <= 1'b1;
                            state_q    <= StDone;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    strobe_vs_track: assert property (@(posedge clk) disable iff (!rst_n) !(cmp_clk && sample));

endmodule

// File: tb/tb_sar_ctrl.sv
// Directed bench for sar_ctrl with a behavioural comparator answering each strobe.
module tb_sar_ctrl;

    localparam int unsigned NBITS = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             cmp_done = 1'b0;
    logic             cmp_vop = 1'b0;
    logic             cmp_von = 1'b0;
    logic             cmp_clk;
    logic             sample;
    logic [NBITS-1:0] dac_code;
    logic [NBITS-1:0] dout;
    logic             dout_valid;
    logic             busy;
    logic             cmp_err;

    int checks = 0;
    int errors = 0;

    // 0: ideal, 1: done stuck low, 2: vop=von=1 on the fifth strobe (bit 3)
    int         mode = 0;
    logic [7:0] target = 8'hA5;
    logic [7:0] trials [16];
    int         ntrial = 0;
    int         overlap = 0;

    sar_ctrl #(
        .NBITS        (NBITS),
        .SAMPLE_CYCLES(2),
        .CMP_TIMEOUT  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cmp_done  (cmp_done),
        .cmp_vop   (cmp_vop),
        .cmp_von   (cmp_von),
        .cmp_clk   (cmp_clk),
        .sample    (sample),
        .dac_code  (dac_code),
        .dout      (dout),
        .dout_valid(dout_valid),
        .busy      (busy),
        .cmp_err   (cmp_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmp_clk && sample) overlap++;
    end

    // Comparator: resolves 2 ns after each strobe edge, well within one clk period
    initial begin
        forever begin
            @(posedge cmp_clk);
            #2;
            if (ntrial < 16) trials[ntrial] = dac_code;
            ntrial++;
            if (mode != 1) begin
                if (mode == 2 && ntrial == 5) begin
                    cmp_vop = 1'b1;
                    cmp_von = 1'b1;
                end else begin
                    cmp_vop = (target >= dac_code);
                    cmp_von = ~cmp_vop;
                end
                cmp_done = 1'b1;
            end
            @(negedge cmp_clk);
            #2;
            cmp_done = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // k counts edges after the accepting edge; sampled on negedges
    task automatic run_conv(output int lat, output int busy_n, output int vp);
        lat    = -1;
        busy_n = 0;
        vp     = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (k > 0) @(negedge clk);
            if (busy) busy_n++;
            if (dout_valid) begin
                vp++;
                if (lat < 0) lat = k;
            end
            if (!busy && k > 0) break;
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check_eq("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        int bn;
        int vp;
        int found;

        repeat (3) @(negedge clk);
        check_eq("rst_cmp_clk", {31'd0, cmp_clk}, 32'd0);
        check_eq("rst_sample", {31'd0, sample}, 32'd0);
        check_eq("rst_dac_code", {24'd0, dac_code}, 32'd0);
        check_eq("rst_dout", {24'd0, dout}, 32'd0);
        check_eq("rst_valid", {31'd0, dout_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_err", {31'd0, cmp_err}, 32'd0);
        rst_n = 1'b1;

        // Ideal comparator, 0xA5
        target = 8'hA5; ntrial = 0;
        run_conv(lat, bn, vp);
        check_eq("a5_latency", lat, 50);
        check_eq("a5_busy_cycles", bn, 51);
        check_eq("a5_valid_pulses", vp, 1);
        check_eq("a5_dout", {24'd0, dout}, 32'hA5);
        check_eq("a5_err", {31'd0, cmp_err}, 32'd0);
        check_eq("a5_dac_hold", {24'd0, dac_code}, 32'hA5);
        check_eq("a5_strobes", ntrial, 8);

        // All decisions vop=1
        target = 8'hFF; ntrial = 0;
        run_conv(lat, bn, vp);
        check_eq("ones_dout", {24'd0, dout}, 32'hFF);
        check_eq("ones_trial0", {24'd0, trials[0]}, 32'h80);
        check_eq("ones_trial1", {24'd0, trials[1]}, 32'hC0);
        check_eq("ones_trial2", {24'd0, trials[2]}, 32'hE0);
        check_eq("ones_trial7", {24'd0, trials[7]}, 32'hFF);

        // All decisions von=1
        target = 8'h00; ntrial = 0;
        run_conv(lat, bn, vp);
        check_eq("zeros_dout", {24'd0, dout}, 32'h00);
        check_eq("zeros_trial0", {24'd0, trials[0]}, 32'h80);
        check_eq("zeros_trial1", {24'd0, trials[1]}, 32'h40);
        check_eq("zeros_trial7", {24'd0, trials[7]}, 32'h01);
        check_eq("zeros_err", {31'd0, cmp_err}, 32'd0);

        // Stuck comparator: 8-cycle COMPARE timeout plus 1-cycle RELEASE per bit
        mode = 1; ntrial = 0;
        run_conv(lat, bn, vp);
        check_eq("stuck_dout", {24'd0, dout}, 32'hFF);
        check_eq("stuck_err", {31'd0, cmp_err}, 32'd1);
        check_eq("stuck_latency", lat, 74);
        check_eq("stuck_pulses", vp, 1);

        // Next accepted start clears cmp_err on SAMPLE entry
        mode = 0; target = 8'hA5;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check_eq("clr_err", {31'd0, cmp_err}, 32'd0);
        check_eq("clr_sample", {31'd0, sample}, 32'd1);
        check_eq("clr_dac_zero", {24'd0, dac_code}, 32'd0);
        wait_idle();
        check_eq("clr_dout", {24'd0, dout}, 32'hA5);

        // Invalid decision on bit 3
        mode = 2; target = 8'hA5; ntrial = 0;
        run_conv(lat, bn, vp);
        check_eq("inv_dout", {24'd0, dout}, 32'hA8);
        check_eq("inv_err", {31'd0, cmp_err}, 32'd1);
        mode = 0;

        // start during COMPARE is dropped
        target = 8'h3C;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("mid_in_compare", {31'd0, sample}, 32'd0);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        vp = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (dout_valid) vp++;
        end
        check_eq("mid_pulses", vp, 1);
        check_eq("mid_dout", {24'd0, dout}, 32'h3C);
        check_eq("mid_idle", {31'd0, busy}, 32'd0);

        // start on the dout_valid cycle is ignored; one cycle later it is accepted
        target = 8'h5A;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        found = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (dout_valid) begin
                found = 1;
                break;
            end
        end
        check_eq("dv_found", found, 1);
        start = 1'b1;
        @(negedge clk);
        check_eq("dv_start_ignored", {31'd0, busy}, 32'd0);
        check_eq("dv_valid_drop", {31'd0, dout_valid}, 32'd0);
        check_eq("dv_dout", {24'd0, dout}, 32'h5A);
        @(negedge clk);
        start = 1'b0;
        check_eq("dv_next_busy", {31'd0, busy}, 32'd1);
        check_eq("dv_next_sample", {31'd0, sample}, 32'd1);
        wait_idle();
        check_eq("dv_second_dout", {24'd0, dout}, 32'h5A);

        // Reset in the middle of a conversion
        target = 8'hA5;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_eq("mrst_cmp_clk", {31'd0, cmp_clk}, 32'd0);
        check_eq("mrst_sample", {31'd0, sample}, 32'd0);
        check_eq("mrst_dac", {24'd0, dac_code}, 32'd0);
        check_eq("mrst_dout", {24'd0, dout}, 32'd0);
        check_eq("mrst_busy", {31'd0, busy}, 32'd0);
        check_eq("mrst_err", {31'd0, cmp_err}, 32'd0);
        vp = 0; bn = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (dout_valid) vp++;
            if (busy) bn++;
        end
        check_eq("mrst_no_valid", vp, 0);
        check_eq("mrst_stays_idle", bn, 0);
        ntrial = 0;
        run_conv(lat, bn, vp);
        check_eq("mrst_restart_dout", {24'd0, dout}, 32'hA5);
        check_eq("mrst_restart_lat", lat, 50);

        check_eq("strobe_track_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sar_ctrl.md
Name: sar_ctrl

Overview:
- Synchronous SAR sequencer for one ADC slice.
- Drives the track/hold switch, the capacitor-DAC trial code and the comparator strobe.
- Reads the comparator's done/vop/von handshake and produces an NBITS result with a one-cycle valid pulse.
- Sits between the slice's sampler/cap-DAC/sense amplifier and the digital back-end.

Parameters:
- NBITS, 8: conversion resolution; legal 2..16.
- SAMPLE_CYCLES, 2: clk cycles with sample high per conversion; legal >=1.
- CMP_TIMEOUT, 8: max clk cycles per strobe phase before a forced decision; legal >=3.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  conversion request; sampled in IDLE only.
- cmp_done  input  1  comparator done (vmp^vmn); asynchronous to clk.
- cmp_vop  input  1  comparator positive decision.
- cmp_von  input  1  comparator negative decision.
- cmp_clk  output  1  comparator strobe (drives asyn_clk).
- sample  output  1  track/hold switch; 1 = track.
- dac_code  output  NBITS  cap-DAC trial code.
- dout  output  NBITS  last conversion result.
- dout_valid  output  1  one-cycle pulse, dout updated.
- busy  output  1  high in every state except IDLE.
- cmp_err  output  1  sticky: a timeout or vop==von occurred in the current/last conversion; cleared on accepted start.

Behaviour:
- Reset applies at a clk edge with rst_n=0:
  - State becomes IDLE.
  - All outputs go to 0: cmp_clk, sample, dac_code, dout, dout_valid, busy, cmp_err.
  - Synchronizer flops, bit index and timeout counter clear.
  - Reset mid-conversion aborts it; no dout_valid is produced and dout keeps 0.
- All outputs are registered; no combinational path from inputs to outputs.
- cmp_done passes through a 2-flop synchronizer (done_s). cmp_vop and cmp_von are sampled directly at the edge where done_s=1 is acted on; they are stable by then.
- FSM states: IDLE, SAMPLE, COMPARE, RELEASE, DONE.
- IDLE:
  - start=1 -> SAMPLE.
  - On entry to SAMPLE: sample=1, dac_code=0, cmp_err=0, busy=1.
- SAMPLE:
  - Held SAMPLE_CYCLES cycles.
  - Then -> COMPARE with sample=0, bit index i=NBITS-1, dac_code[i]=1, cmp_clk=1, timeout counter=0.
- COMPARE:
  - Counter increments each cycle.
  - When done_s=1: dac_code[i] <= cmp_vop (bit kept if vip>=vin); cmp_clk=0; counter=0; -> RELEASE.
  - If cmp_vop==cmp_von at that edge: bit <= cmp_vop and cmp_err=1.
  - If counter reaches CMP_TIMEOUT-1 with done_s=0: bit forced to 1, cmp_err=1, cmp_clk=0, -> RELEASE.
- RELEASE:
  - Wait for done_s=0 (comparator reset), same counter/timeout rule; timeout sets cmp_err=1.
  - Exit when i>0: i<=i-1, dac_code[i-1]=1, cmp_clk=1 -> COMPARE.
  - Exit when i==0: dout<=dac_code, dout_valid=1 -> DONE.
- DONE:
  - One cycle; dout_valid drops, busy drops -> IDLE.
  - dac_code holds the final code until the next SAMPLE entry.
- start while busy is ignored, not queued.
- Latency with a comparator resolving within one clk of each strobe edge:
  - Each of COMPARE and RELEASE lasts 3 cycles, i.e. 6 cycles/bit.
  - dout_valid is high in the cycle starting SAMPLE_CYCLES+6*NBITS edges after the edge that accepted start.
- Simultaneous start with dout_valid (DONE state) is ignored; start is accepted only from the following cycle in IDLE.
- cmp_clk is never high while sample=1.
- dac_code changes only on edges where cmp_clk goes 1 (new trial bit) or at a COMPARE decision.

Test Plan:
- Reset check: rst_n=0 for 2 cycles mid-conversion, then 1 -> all outputs 0, state IDLE, no dout_valid until a new start.
- Ideal comparator, vip representing 0xA5, NBITS=8, SAMPLE_CYCLES=2: one start pulse -> dout=0xA5 and dout_valid single pulse exactly 50 edges after start; busy high 51 cycles; cmp_err=0.
- Boundary codes: comparator always vop=1 -> dout=0xFF; always von=1 -> dout=0x00; trial code sequence 0x80,0x40.. (all-zero case) and 0x80,0xC0,..,0xFF (all-one case) on dac_code.
- Comparator stuck (cmp_done held 0) with CMP_TIMEOUT=8 -> each bit forced 1, dout=0xFF, cmp_err=1; next start clears cmp_err in its SAMPLE cycle.
- Invalid decision vop=von=1 on bit 3 only -> that bit=1, cmp_err=1, other bits correct.
- start re-pulsed during COMPARE and on the dout_valid cycle -> ignored; exactly one conversion; a start one cycle later is accepted.
